gate_bist_ctrl: RTL and testbench

Built-in self-test sequencer for a small N-input combinational gate (default: the 3-input OR gate, stim[2]=A, stim[1]=B, stim[0]=C).
- On start, drives every input combination 0..2^N_IN-1 in ascending order into the gate under test.
- Waits a programmable settle time per vector, samples the gate output and compares it against a truth-table parameter.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits between the gate instance and a top-level test harness, replacing hand-written stimulus sequences.

---
 rtl/gate_bist_ctrl_if.sv | 25 ++
 rtl/gate_bist_ctrl.sv | 138 +++++++++++++
 tb/tb_gate_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_ctrl_if.sv
// Signal bundle between the gate BIST sequencer and the test harness / gate under test.
// The harness side uses the master modport and the sequencer uses the slave modport.
interface gate_bist_ctrl_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic            y_in;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, y_in,
    input  stim, busy, done, pass, err_cnt, fail_valid, first_fail
  );

  modport slave (
    input  start, y_in,
    output stim, busy, done, pass, err_cnt, fail_valid, first_fail
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks every input vector of a small combinational gate in order,
// compares the sampled gate output against a golden truth table and reports the result.
module gate_bist_ctrl #(
  parameter int                    N_IN   = 3,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  GOLDEN = 8'hFE
) (
  input  logic           clk,
  input  logic           rst,
  gate_bist_ctrl_if.slave bist
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [N_IN-1:0] LAST_IDX    = '1;
  localparam logic [3:0]      WAIT_LAST   = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time the compare happens in the cycle right after a vector is driven.
  localparam state_e          AFTER_DRIVE = (SETTLE == 0) ? S_CHECK : S_SETTLE;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [3:0]      waitCnt_q, waitCnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   errCnt_q, errCnt_d;
  logic            failValid_q, failValid_d;
  logic [N_IN-1:0] firstFail_q, firstFail_d;

  logic            mismatch;
  logic [N_IN:0]   errNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      stim_q      <= '0;
      waitCnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCnt_q    <= '0;
      failValid_q <= 1'b0;
      firstFail_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stim_q      <= stim_d;
      waitCnt_q   <= waitCnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      errCnt_q    <= errCnt_d;
      failValid_q <= failValid_d;
      firstFail_q <= firstFail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stim_d      = stim_q;
    waitCnt_d   = waitCnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    errCnt_d    = errCnt_q;
    failValid_d = failValid_q;
    firstFail_d = firstFail_q;
    mismatch    = 1'b0;
    errNext     = errCnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bist.start) begin
          idx_d       = '0;
          stim_d      = '0;
          waitCnt_d   = '0;
          errCnt_d    = '0;
          failValid_d = 1'b0;
          firstFail_d = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = AFTER_DRIVE;
        end
      end
      S_SETTLE: begin
        if (waitCnt_q == WAIT_LAST) begin
          waitCnt_d = '0;
          state_d   = S_CHECK;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        mismatch = (bist.y_in != GOLDEN[idx_q]);
        errNext  = errCnt_q + {{N_IN{1'b0}}, mismatch};
        errCnt_d = errNext;
        if (mismatch && !failValid_q) begin
          firstFail_d = idx_q;
          failValid_d = 1'b1;
        end
        // Done and the verdict are registered together so pass already reflects the last compare.
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (errNext == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          stim_d  = idx_q + 1'b1;
          state_d = AFTER_DRIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bist.stim       = stim_q;
  assign bist.busy       = busy_q;
  assign bist.done       = done_q;
  assign bist.pass       = pass_q;
  assign bist.err_cnt    = errCnt_q;
  assign bist.fail_valid = failValid_q;
  assign bist.first_fail = firstFail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: expected run results are queued at start and
// checked by per-instance monitors whenever a done pulse appears.
module tb_gate_bist_ctrl;

  localparam int N = 3;

  typedef enum int {GATE_OR, GATE_SA0, GATE_SA1, GATE_NO_C} gate_e;

  typedef struct {
    logic         pass;
    logic [N:0]   errCnt;
    logic         failValid;
    logic [N-1:0] firstFail;
    int           busyCycles;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  gate_e gateModeA = GATE_OR;
  gate_e gateModeB = GATE_OR;
  exp_t  expA[$];
  exp_t  expB[$];
  int    compared   = 0;
  int    mismatched = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl_if #(.N_IN(N)) busA ();
  gate_bist_ctrl_if #(.N_IN(N)) busB ();

  gate_bist_ctrl #(.N_IN(N), .SETTLE(1), .GOLDEN(8'hFE)) dutA (
    .clk (clk),
    .rst (rst),
    .bist(busA)
  );

  gate_bist_ctrl #(.N_IN(N), .SETTLE(0), .GOLDEN(8'hFE)) dutB (
    .clk (clk),
    .rst (rst),
    .bist(busB)
  );

  function automatic logic gateEval(input gate_e m, input logic [N-1:0] s);
    case (m)
      GATE_OR:  return |s;
      GATE_SA0: return 1'b0;
      GATE_SA1: return 1'b1;
      default:  return s[2] | s[1];
    endcase
  endfunction

  always_comb busA.y_in = gateEval(gateModeA, busA.stim);
  always_comb busB.y_in = gateEval(gateModeB, busB.stim);

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic checkRun(input string tag, input exp_t e, input logic pass, input logic [N:0] ec,
                          input logic fv, input logic [N-1:0] ff, input int bc, input int stimBad);
    checkOutput({tag, "_pass"}, 32'(pass), 32'(e.pass));
    checkOutput({tag, "_err_cnt"}, 32'(ec), 32'(e.errCnt));
    checkOutput({tag, "_fail_valid"}, 32'(fv), 32'(e.failValid));
    checkOutput({tag, "_first_fail"}, 32'(ff), 32'(e.firstFail));
    checkOutput({tag, "_busy_cycles"}, 32'(bc), 32'(e.busyCycles));
    checkOutput({tag, "_stim_seq_bad"}, 32'(stimBad), 32'd0);
  endtask

  // Monitor for the SETTLE=1 instance: each vector should be held for two busy cycles.
  int busyCntA = 0;
  int stimBadA = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyCntA = 0;
      stimBadA = 0;
    end else begin
      if (busA.busy) begin
        if (32'(busA.stim) !== 32'(busyCntA / 2)) stimBadA++;
        busyCntA++;
      end
      if (busA.done) begin
        if (expA.size() == 0) begin
          checkOutput("A_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expA.pop_front();
          checkRun("A", e, busA.pass, busA.err_cnt, busA.fail_valid, busA.first_fail, busyCntA, stimBadA);
        end
        busyCntA = 0;
        stimBadA = 0;
      end
    end
  end

  // Monitor for the SETTLE=0 instance: each vector should be held for one busy cycle.
  int busyCntB = 0;
  int stimBadB = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyCntB = 0;
      stimBadB = 0;
    end else begin
      if (busB.busy) begin
        if (32'(busB.stim) !== 32'(busyCntB)) stimBadB++;
        busyCntB++;
      end
      if (busB.done) begin
        if (expB.size() == 0) begin
          checkOutput("B_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expB.pop_front();
          checkRun("B", e, busB.pass, busB.err_cnt, busB.fail_valid, busB.first_fail, busyCntB, stimBadB);
        end
        busyCntB = 0;
        stimBadB = 0;
      end
    end
  end

  task automatic applyStimulus(input int which, input gate_e mode, input exp_t e, input bit expectDone);
    @(posedge clk); #1;
    if (which == 0) begin
      gateModeA  = mode;
      busA.start = 1'b1;
      if (expectDone) expA.push_back(e);
    end else begin
      gateModeB  = mode;
      busB.start = 1'b1;
      if (expectDone) expB.push_back(e);
    end
    @(posedge clk); #1;
    busA.start = 1'b0;
    busB.start = 1'b0;
  endtask

  task automatic waitIdle(input int which, input int maxCycles);
    int n = 0;
    while (((which == 0) ? expA.size() : expB.size()) != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    if (((which == 0) ? expA.size() : expB.size()) != 0)
      checkOutput("run_timeout", 32'd1, 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic waitStimA(input logic [N-1:0] value, input int maxCycles);
    int n = 0;
    while (busA.stim !== value && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("wait_stim_reached", 32'(busA.stim), 32'(value));
  endtask

  function automatic exp_t mkExp(input logic p, input int ec, input logic fv, input int ff, input int bc);
    exp_t e;
    e.pass       = p;
    e.errCnt     = (N+1)'(ec);
    e.failValid  = fv;
    e.firstFail  = N'(ff);
    e.busyCycles = bc;
    return e;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    busA.start = 1'b0;
    busB.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_stim", 32'(busA.stim), 32'd0);
      checkOutput("rst_busy", 32'(busA.busy), 32'd0);
      checkOutput("rst_done", 32'(busA.done), 32'd0);
      checkOutput("rst_pass", 32'(busA.pass), 32'd0);
      checkOutput("rst_err_cnt", 32'(busA.err_cnt), 32'd0);
      checkOutput("rst_fail_valid", 32'(busA.fail_valid), 32'd0);
      checkOutput("rst_B_busy", 32'(busB.busy), 32'd0);
    end

    $display("[TB] correct OR gate");
    applyStimulus(0, GATE_OR, mkExp(1'b1, 0, 1'b0, 0, 16), 1'b1);
    waitIdle(0, 60);

    $display("[TB] stuck-at-0 gate");
    applyStimulus(0, GATE_SA0, mkExp(1'b0, 7, 1'b1, 1, 16), 1'b1);
    waitIdle(0, 60);

    $display("[TB] stuck-at-1 gate");
    applyStimulus(0, GATE_SA1, mkExp(1'b0, 1, 1'b1, 0, 16), 1'b1);
    waitIdle(0, 60);

    $display("[TB] gate ignoring C");
    applyStimulus(0, GATE_NO_C, mkExp(1'b0, 1, 1'b1, 1, 16), 1'b1);
    waitIdle(0, 60);

    $display("[TB] start repeated mid-run");
    applyStimulus(0, GATE_OR, mkExp(1'b1, 0, 1'b0, 0, 16), 1'b1);
    waitStimA(3'd3, 40);
    applyStimulus(0, GATE_OR, mkExp(1'b1, 0, 1'b0, 0, 16), 1'b0);
    waitIdle(0, 60);
    repeat (30) @(posedge clk);
    #1;

    $display("[TB] reset mid-run");
    applyStimulus(0, GATE_SA0, mkExp(1'b0, 0, 1'b0, 0, 0), 1'b0);
    waitStimA(3'd4, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_stim", 32'(busA.stim), 32'd0);
    checkOutput("midrst_busy", 32'(busA.busy), 32'd0);
    checkOutput("midrst_done", 32'(busA.done), 32'd0);
    checkOutput("midrst_pass", 32'(busA.pass), 32'd0);
    checkOutput("midrst_err_cnt", 32'(busA.err_cnt), 32'd0);
    checkOutput("midrst_fail_valid", 32'(busA.fail_valid), 32'd0);
    checkOutput("midrst_first_fail", 32'(busA.first_fail), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midrst_still_idle", 32'(busA.busy), 32'd0);

    $display("[TB] run after reset");
    applyStimulus(0, GATE_OR, mkExp(1'b1, 0, 1'b0, 0, 16), 1'b1);
    waitIdle(0, 60);

    $display("[TB] zero settle instance");
    applyStimulus(1, GATE_OR, mkExp(1'b1, 0, 1'b0, 0, 8), 1'b1);
    waitIdle(1, 40);
    applyStimulus(1, GATE_SA0, mkExp(1'b0, 7, 1'b1, 1, 8), 1'b1);
    waitIdle(1, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
